ultrasonido_controlador: RTL and testbench
==========================================

// Module: ultrasonido_controlador
// PURPOSE
//  Sequencer for the HC-SR04 ultrasonic ranger: issues the 10 us trigger pulse, times the echo
//  return, and converts its width to centimetres with a counter, so no divider is needed.
//  Supports single-shot and free-running measurement at a fixed repetition period. Reports
//  timeouts and holds the last good distance for the display/FSM logic downstream.
// PARAMETERS
//  TRIG_CYCLES          500        trigger high time in clk cycles (10 us @ 50 MHz)
//  CM_DIV_CYCLES        2900       echo-high clk cycles per 1 cm (58 us @ 50 MHz)
//  ECHO_TIMEOUT_CYCLES  1900000    max cycles in WAIT_ECHO or in MEASURE (38 ms)
//  PERIOD_CYCLES        3000000    min cycles from one trigger rise to the next (60 ms)
//  DIST_W               9          width of distance_cm
// PORTS
//  clk          in   1       system clock, 50 MHz
//  rst          in   1       asynchronous, active-high reset
//  start        in   1       single-shot request; sampled only in IDLE
//  continuous   in   1       1 = free-run; a new cycle starts on each IDLE visit
//  echo         in   1       raw sensor echo (asynchronous to clk)
//  trigger      out  1       sensor trigger pulse
//  busy         out  1       1 in every state except IDLE
//  distance_cm  out  DIST_W  last measured distance; held between measurements
//  valid        out  1       1-cycle pulse when distance_cm is updated by a good echo
//  timeout      out  1       1-cycle pulse when a measurement is aborted
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, all counters=0, trigger=0, busy=0, valid=0,
//   timeout=0, distance_cm=0, sync flops=0.
//  echo passes through a 2-FF synchroniser (echo_s), plus one registered copy for edge detect.
//   Rise/fall detection therefore lags the pin by 2 cycles.
//  FSM, all outputs registered:
//   IDLE:      if start|continuous -> TRIG; clear the cm/sub counters, the period counter
//              and the timeout counter.
//   TRIG:      trigger=1 for exactly TRIG_CYCLES cycles, then trigger=0 -> WAIT_ECHO.
//   WAIT_ECHO: waits for a RISING edge of echo_s. A level already high is ignored.
//              Rising edge -> MEASURE. Timeout counter reaching ECHO_TIMEOUT_CYCLES
//              -> timeout pulse, distance_cm unchanged -> HOLDOFF.
//   MEASURE:   sub counter counts 0..CM_DIV_CYCLES-1. On wrap, cm counter +1,
//              saturating at 2^DIST_W-1.
//              Falling edge of echo_s -> distance_cm<=cm counter, valid=1 -> HOLDOFF.
//              Timeout counter restarts on MEASURE entry. If it reaches
//              ECHO_TIMEOUT_CYCLES -> distance_cm<=all-ones, timeout=1 -> HOLDOFF.
//   HOLDOFF:   waits until the period counter (started on TRIG entry) reaches PERIOD_CYCLES-1
//              -> IDLE. valid and timeout are never both 1.
//  Distance is truncated: a partial centimetre at echo fall is dropped.
//  start while busy is ignored, not queued. Deasserting continuous mid-cycle finishes the
//   current measurement; the block then stays in IDLE.
//  Trigger rises are spaced by at least PERIOD_CYCLES+1 cycles (IDLE costs one cycle).
//  Counter widths are sized by $clog2 of their limits; no counter wraps silently.
//  Reset asserted mid-TRIG drops trigger in the same cycle (async clear).
// TESTING  (override: TRIG=5, CM_DIV=10, ECHO_TIMEOUT=1000, PERIOD=2000)
//  1 start pulse in IDLE -> trigger high exactly 5 cycles, busy=1 from the next cycle
//  2 echo high 235 cycles after trigger -> distance_cm=23, one valid pulse, timeout=0
//  3 echo never rises -> timeout pulse 1000 cycles after trigger falls; distance_cm keeps 23
//  4 echo stuck high >1000 cycles -> distance_cm=511, timeout pulse, no valid
//  5 continuous=1, echo 50 cycles -> trigger rises 2001 cycles apart, distance_cm=5 each
//  6 rst in MEASURE -> trigger=0, busy=0, distance_cm=0 at once; start ignored while busy

Source files
------------

// File: rtl/ultrasonido_controlador.sv
// HC-SR04 ranger sequencer: trigger pulse, echo timing, counter-based conversion to cm,
// single-shot or free-running at a fixed repetition period, with timeout reporting.
module ultrasonido_controlador #(
    parameter int TRIG_CYCLES         = 500,
    parameter int CM_DIV_CYCLES       = 2900,
    parameter int ECHO_TIMEOUT_CYCLES = 1900000,
    parameter int PERIOD_CYCLES       = 3000000,
    parameter int DIST_W              = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              echo,
    output logic              trigger,
    output logic              busy,
    output logic [DIST_W-1:0] distance_cm,
    output logic              valid,
    output logic              timeout
);

    localparam int TRIG_W = $clog2(TRIG_CYCLES);
    localparam int SUB_W  = $clog2(CM_DIV_CYCLES);
    localparam int TMO_W  = $clog2(ECHO_TIMEOUT_CYCLES);
    localparam int PER_W  = $clog2(PERIOD_CYCLES);

    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CM_DIV_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ECHO_TIMEOUT_CYCLES - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF} state_t;

    state_t              state_reg, state_next;
    logic [TRIG_W-1:0]   trig_cnt_reg, trig_cnt_next;
    logic [SUB_W-1:0]    sub_cnt_reg, sub_cnt_next;
    logic [DIST_W-1:0]   cm_cnt_reg, cm_cnt_next;
    logic [TMO_W-1:0]    tmo_cnt_reg, tmo_cnt_next;
    logic [PER_W-1:0]    per_cnt_reg, per_cnt_next;
    logic                trigger_reg, trigger_next;
    logic                busy_reg, busy_next;
    logic [DIST_W-1:0]   dist_reg, dist_next;
    logic                valid_reg, valid_next;
    logic                timeout_reg, timeout_next;
    logic                echo_meta_reg, echo_s_reg, echo_d_reg;
    logic                echo_rise, echo_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_meta_reg <= 1'b0;
            echo_s_reg    <= 1'b0;
            echo_d_reg    <= 1'b0;
        end else begin
            echo_meta_reg <= echo;
            echo_s_reg    <= echo_meta_reg;
            echo_d_reg    <= echo_s_reg;
        end
    end

    assign echo_rise = echo_s_reg & ~echo_d_reg;
    assign echo_fall = ~echo_s_reg & echo_d_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            trig_cnt_reg <= '0;
            sub_cnt_reg  <= '0;
            cm_cnt_reg   <= '0;
            tmo_cnt_reg  <= '0;
            per_cnt_reg  <= '0;
            trigger_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            dist_reg     <= '0;
            valid_reg    <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            trig_cnt_reg <= trig_cnt_next;
            sub_cnt_reg  <= sub_cnt_next;
            cm_cnt_reg   <= cm_cnt_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            per_cnt_reg  <= per_cnt_next;
            trigger_reg  <= trigger_next;
            busy_reg     <= busy_next;
            dist_reg     <= dist_next;
            valid_reg    <= valid_next;
            timeout_reg  <= timeout_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        trig_cnt_next = trig_cnt_reg;
        sub_cnt_next  = sub_cnt_reg;
        cm_cnt_next   = cm_cnt_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        per_cnt_next  = per_cnt_reg;
        trigger_next  = trigger_reg;
        busy_next     = busy_reg;
        dist_next     = dist_reg;
        valid_next    = 1'b0;
        timeout_next  = 1'b0;

        // Period counter runs from trigger rise and saturates so HOLDOFF always sees its limit.
        if (state_reg != IDLE && per_cnt_reg != PER_LAST)
            per_cnt_next = per_cnt_reg + 1'b1;

        case (state_reg)
            IDLE: begin
                trig_cnt_next = '0;
                sub_cnt_next  = '0;
                cm_cnt_next   = '0;
                tmo_cnt_next  = '0;
                per_cnt_next  = '0;
                if (start || continuous) begin
                    state_next   = TRIG;
                    trigger_next = 1'b1;
                    busy_next    = 1'b1;
                end
            end
            TRIG: begin
                if (trig_cnt_reg == TRIG_LAST) begin
                    trigger_next = 1'b0;
                    state_next   = WAIT_ECHO;
                end else begin
                    trig_cnt_next = trig_cnt_reg + 1'b1;
                end
            end
            WAIT_ECHO: begin
                if (echo_rise) begin
                    // The edge-detect cycle already has echo_s high, so it counts as the first tick.
                    state_next   = MEASURE;
                    tmo_cnt_next = '0;
                    sub_cnt_next = SUB_W'(1);
                    cm_cnt_next  = '0;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = HOLDOFF;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            MEASURE: begin
                if (echo_fall) begin
                    dist_next  = cm_cnt_reg;
                    valid_next = 1'b1;
                    state_next = HOLDOFF;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    dist_next    = '1;
                    timeout_next = 1'b1;
                    state_next   = HOLDOFF;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                    if (sub_cnt_reg == SUB_LAST) begin
                        sub_cnt_next = '0;
                        if (cm_cnt_reg != '1)
                            cm_cnt_next = cm_cnt_reg + 1'b1;
                    end else begin
                        sub_cnt_next = sub_cnt_reg + 1'b1;
                    end
                end
            end
            HOLDOFF: begin
                if (per_cnt_reg == PER_LAST) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next   = IDLE;
                trigger_next = 1'b0;
                busy_next    = 1'b0;
            end
        endcase
    end

    assign trigger     = trigger_reg;
    assign busy        = busy_reg;
    assign distance_cm = dist_reg;
    assign valid       = valid_reg;
    assign timeout     = timeout_reg;

endmodule

// File: tb/tb_ultrasonido_controlador.sv
// Directed bench for ultrasonido_controlador with small timing parameters.
module tb_ultrasonido_controlador;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic       echo = 1'b0;
    logic       trigger, busy, valid, timeout;
    logic [8:0] distance_cm;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    ultrasonido_controlador #(
        .TRIG_CYCLES(5), .CM_DIV_CYCLES(10), .ECHO_TIMEOUT_CYCLES(1000),
        .PERIOD_CYCLES(2000), .DIST_W(9)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .echo(echo),
        .trigger(trigger), .busy(busy), .distance_cm(distance_cm),
        .valid(valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_trig_fall();
        int n = 0;
        while (trigger && n < 100) begin tick(); n++; end
        check_eq("trig_fell", trigger, 0);
    endtask

    task automatic wait_idle(output int nv, output int nt);
        int n = 0;
        nv = 0; nt = 0;
        while (busy && n < 5000) begin
            tick(); n++;
            if (valid) nv++;
            if (timeout) nt++;
        end
        check_eq("idle_reached", busy, 0);
    endtask

    initial begin
        int cnt, nv, nt, seen;
        int rise_t [3];

        // Reset state
        repeat (3) tick();
        check_eq("rst_trigger", trigger, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_dist", distance_cm, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_timeout", timeout, 0);
        rst = 1'b0;
        repeat (2) tick();

        // 1: trigger width and busy
        pulse_start();
        check_eq("t1_busy", busy, 1);
        cnt = 0;
        while (trigger && cnt < 100) begin cnt++; tick(); end
        check_eq("t1_trig_width", cnt, 5);

        // 2: 235-cycle echo -> 23 cm; a start while busy is dropped
        echo = 1'b1;
        repeat (10) tick();
        pulse_start();
        repeat (224) tick();
        echo = 1'b0;
        wait_idle(nv, nt);
        check_eq("t2_dist", distance_cm, 23);
        check_eq("t2_valid_cnt", nv, 1);
        check_eq("t2_timeout_cnt", nt, 0);
        seen = 0;
        repeat (30) begin tick(); if (trigger || busy) seen = 1; end
        check_eq("t2_no_queue", seen, 0);

        // 3: no echo -> timeout 1000 cycles after trigger falls, distance held
        pulse_start();
        wait_trig_fall();
        cnt = 0;
        while (!timeout && cnt < 2000) begin tick(); cnt++; end
        check_eq("t3_tmo_delay", cnt, 1000);
        check_eq("t3_dist_held", distance_cm, 23);
        wait_idle(nv, nt);
        check_eq("t3_valid_cnt", nv, 0);

        // 4: echo stuck high -> saturated distance, timeout, no valid
        pulse_start();
        wait_trig_fall();
        echo = 1'b1;
        nv = 0; nt = 0;
        repeat (1100) begin tick(); if (valid) nv++; if (timeout) nt++; end
        echo = 1'b0;
        check_eq("t4_dist", distance_cm, 511);
        check_eq("t4_timeout_cnt", nt, 1);
        check_eq("t4_valid_cnt", nv, 0);
        wait_idle(nv, nt);

        // 5: free-running, 50-cycle echoes
        continuous = 1'b1;
        for (int m = 0; m < 3; m++) begin
            cnt = 0;
            while (!trigger && cnt < 5000) begin tick(); cnt++; end
            rise_t[m] = cyc;
            wait_trig_fall();
            echo = 1'b1;
            repeat (50) tick();
            echo = 1'b0;
            cnt = 0;
            while (!valid && cnt < 200) begin tick(); cnt++; end
            check_eq($sformatf("t5_dist%0d", m), distance_cm, 5);
        end
        check_eq("t5_spacing01", rise_t[1] - rise_t[0], 2001);
        check_eq("t5_spacing12", rise_t[2] - rise_t[1], 2001);
        continuous = 1'b0;
        wait_idle(nv, nt);
        seen = 0;
        repeat (30) begin tick(); if (trigger || busy) seen = 1; end
        check_eq("t5_stays_idle", seen, 0);

        // 6: async reset while measuring
        pulse_start();
        wait_trig_fall();
        echo = 1'b1;
        repeat (20) tick();
        check_eq("t6_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check_eq("t6_trigger", trigger, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_dist", distance_cm, 0);
        echo = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
